// File: rtl/por_sequencer.sv
// -----------------------------------------------------------------------------
// por_sequencer
//   Power-on / relock reset sequencer. Waits for a qualified PLL lock, counts
//   DELAY cycles, then releases NUM_CH active-high reset outputs one at a time,
//   STAGE_GAP cycles apart. Loss of lock or a software request re-asserts every
//   output and restarts the sequence. Lock losses are counted (saturating).
//
//   Optional build macro: POR_LOCK_FILTER_EN
//     defined   : lock_q rises only after LOCK_FILT consecutive high
//                 synchronized samples and drops on the first low sample.
//     undefined : lock_q is the synchronizer output; LOCK_FILT has no effect.
// -----------------------------------------------------------------------------
module por_sequencer #(
    parameter int DELAY     = 1023,
    parameter int CNT_W     = 10,
    parameter int NUM_CH    = 2,
    parameter int STAGE_GAP = 16,
    parameter int LOCK_FILT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic [7:0]        relock_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        STAGE     = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int                IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  DELAY_L  = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0]  GAP_L    = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ALL_ONES = {NUM_CH{1'b1}};

    // Elaboration-time parameter sanity checks
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("por_sequencer: NUM_CH must be in 1..8");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("por_sequencer: STAGE_GAP must be >= 1");
    end
    if (LOCK_FILT < 1) begin : g_bad_filt
        $error("por_sequencer: LOCK_FILT must be >= 1");
    end
    if (CNT_W < 31 && (DELAY >= (1 << CNT_W) || STAGE_GAP >= (1 << CNT_W))) begin : g_bad_cnt_w
        $error("por_sequencer: DELAY and STAGE_GAP must fit in CNT_W bits");
    end

    // ------------------------------------------------------------------
    // Lock synchronizer and optional qualification filter
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic sync2_reg;
    logic lock_q;

    // Two-flop synchronizer for the asynchronous PLL lock input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pll_locked;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef POR_LOCK_FILTER_EN
    localparam int               FILT_W    = $clog2(LOCK_FILT + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);
    localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);

    logic [FILT_W-1:0] filt_cnt_reg;
    logic              lock_q_reg;

    // Count consecutive high samples; any low sample drops lock_q at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (!sync2_reg) begin
            filt_cnt_reg <= '0;
            lock_q_reg   <= 1'b0;
        end else if (filt_cnt_reg == FILT_LAST) begin
            lock_q_reg   <= 1'b1;
        end else begin
            filt_cnt_reg <= filt_cnt_reg + FILT_ONE;
        end
    end

    assign lock_q = lock_q_reg;
`else
    assign lock_q = sync2_reg;
`endif

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [IDX_W-1:0]  idx_reg,     idx_next;
    logic [NUM_CH-1:0] rst_out_reg, rst_out_next;
    logic              ready_reg,   ready_next;
    logic [7:0]        relock_reg,  relock_next;

    logic              active;
    logic              loss;
    logic              abort;
    logic              start;
    logic              cnt_done;
    logic              rel0;
    logic              rel_stage;
    logic              last_stage;
    logic [NUM_CH-1:0] stage_mask;

    // One-hot mask of the channel addressed by the stage index
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stage_mask
        assign stage_mask[gi] = (idx_reg == IDX_W'(gi));
    end

    // Shared event decode. The counter fires on the cycle it would reach
    // zero, so a load of N gives exactly N cycles in COUNT/STAGE.
    assign active     = (state_reg != WAIT_LOCK);
    assign loss       = active && !lock_q;
    assign abort      = active && (!lock_q || sw_rst_req);
    assign start      = (state_reg == WAIT_LOCK) && lock_q;
    assign cnt_done   = (cnt_reg <= CNT_ONE);
    assign rel0       = ((state_reg == COUNT) && !abort && cnt_done) ||
                        (start && (DELAY == 0));
    assign rel_stage  = (state_reg == STAGE) && !abort && cnt_done;
    assign last_stage = (idx_reg == LAST_IDX);

    // State register: FSM state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= WAIT_LOCK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= ALL_ONES;
            ready_reg   <= 1'b0;
            relock_reg  <= 8'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            rst_out_reg <= rst_out_next;
            ready_reg   <= ready_next;
            relock_reg  <= relock_next;
        end
    end

    // Next-state logic: lock loss / software restart beats everything
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (abort) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
            idx_next   = '0;
        end else if (rel0) begin
            if (NUM_CH == 1) begin
                state_next = RUN;
                cnt_next   = '0;
                idx_next   = '0;
            end else begin
                state_next = STAGE;
                cnt_next   = GAP_L;
                idx_next   = IDX_ONE;
            end
        end else if (rel_stage) begin
            if (last_stage) begin
                state_next = RUN;
                cnt_next   = '0;
            end else begin
                idx_next   = idx_reg + IDX_ONE;
                cnt_next   = GAP_L;
            end
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    if (start) begin
                        state_next = COUNT;
                        cnt_next   = DELAY_L;
                    end
                end
                COUNT, STAGE: cnt_next = cnt_reg - CNT_ONE;
                default:      cnt_next = cnt_reg;
            endcase
        end
    end

    // Output logic: next values for the registered resets, ready and counter
    always_comb begin
        rst_out_next = rst_out_reg;
        ready_next   = ready_reg;
        relock_next  = relock_reg;
        if (abort) begin
            rst_out_next = ALL_ONES;
            ready_next   = 1'b0;
            if (loss && relock_reg != 8'hFF) begin
                relock_next = relock_reg + 8'd1;
            end
        end else if (rel0) begin
            rst_out_next    = ALL_ONES;
            rst_out_next[0] = 1'b0;
            ready_next      = (NUM_CH == 1);
        end else if (rel_stage) begin
            rst_out_next = rst_out_reg & ~stage_mask;
            ready_next   = last_stage;
        end else if (state_reg == WAIT_LOCK) begin
            rst_out_next = ALL_ONES;
            ready_next   = 1'b0;
        end
    end

    assign rst_out    = rst_out_reg;
    assign ready      = ready_reg;
    assign relock_cnt = relock_reg;

endmodule

// File: tb/tb_por_sequencer.sv
// -----------------------------------------------------------------------------
// tb_por_sequencer
//   Directed bench for por_sequencer with DELAY=8, STAGE_GAP=4, NUM_CH=3,
//   LOCK_FILT=4. Cycle k means the values visible just after the k-th rising
//   edge counted from the step's start. Works with or without
//   POR_LOCK_FILTER_EN; lock latencies adjust accordingly.
// -----------------------------------------------------------------------------
module tb_por_sequencer;

    localparam int DELAY = 8;
    localparam int GAP   = 4;
    localparam int NCH   = 3;
    localparam int LF    = 4;
`ifdef POR_LOCK_FILTER_EN
    localparam int FILT  = LF;
    localparam int FALL  = 3;   // pll low at cycle m -> lock_q low at m+FALL
`else
    localparam int FILT  = 0;
    localparam int FALL  = 2;
`endif
    localparam int LQ    = 2 + FILT;          // pll rise -> lock_q high
    localparam int REL0  = LQ + DELAY + 1;    // pll rise -> rst_out[0] low
    localparam int P     = 7 + FILT;          // spacing of repeated glitches

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pll_locked;
    logic           sw_rst_req;
    logic [NCH-1:0] rst_out;
    logic           ready;
    logic [7:0]     relock_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0;

    por_sequencer #(
        .DELAY     (DELAY),
        .CNT_W     (10),
        .NUM_CH    (NCH),
        .STAGE_GAP (GAP),
        .LOCK_FILT (LF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .ready      (ready),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            $display("[TB] ok   %s = %0h", tag, obs);
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e_rst, input int e_rdy, input int e_rel);
        chk({tag, ".rst_out"},    32'(rst_out),    e_rst);
        chk({tag, ".ready"},      32'(ready),      e_rdy);
        chk({tag, ".relock_cnt"}, 32'(relock_cnt), e_rel);
    endtask

    // Drop pll_locked for exactly one cycle starting now
    task automatic glitch();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
    endtask

    initial begin
        int m;
        int r;
        int s;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_rst_req = 1'b0;

        // Reset held for three edges
        repeat (3) tick();
        chk_out("reset", 7, 0, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk_out("idle_hold", 7, 0, 0);

        // Software request in WAIT_LOCK is ignored
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        tick();
        chk_out("sw_in_wait", 7, 0, 0);

`ifdef POR_LOCK_FILTER_EN
        // Three-cycle glitch must not qualify
        t0 = cyc;
        pll_locked = 1'b1;
        go(t0 + 3);
        pll_locked = 1'b0;
        go(t0 + 30);
        chk_out("glitch3", 7, 0, 0);
`endif

        // Startup
        t0 = cyc;
        pll_locked = 1'b1;
        go(t0 + REL0 - 1);         chk_out("start_pre0", 7, 0, 0);
        go(t0 + REL0);             chk_out("start_rel0", 6, 0, 0);
        go(t0 + REL0 + GAP - 1);   chk_out("start_pre1", 6, 0, 0);
        go(t0 + REL0 + GAP);       chk_out("start_rel1", 4, 0, 0);
        go(t0 + REL0 + 2*GAP - 1); chk_out("start_pre2", 4, 0, 0);
        go(t0 + REL0 + 2*GAP);     chk_out("start_rel2", 0, 1, 0);
        go(t0 + REL0 + 2*GAP + 5); chk_out("run_hold", 0, 1, 0);

        // Lock loss in RUN and full replay
        m = cyc;
        glitch();
        go(m + FALL);              chk_out("loss_pre", 0, 1, 0);
        go(m + FALL + 1);          chk_out("loss_hit", 7, 0, 1);
        r = m + 1 + LQ;
        go(r + DELAY);             chk_out("replay_pre0", 7, 0, 1);
        go(r + DELAY + 1);         chk_out("replay_rel0", 6, 0, 1);
        go(r + DELAY + 1 + GAP);   chk_out("replay_rel1", 4, 0, 1);
        go(r + DELAY + 1 + 2*GAP); chk_out("replay_rel2", 0, 1, 1);

        // Software reset from RUN
        s = cyc;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk_out("sw_run", 7, 0, 1);
        go(s + 1 + DELAY + 1);     chk_out("sw_run_rel0", 6, 0, 1);

        // Software reset while rst_out = 3'b110
        s = cyc;
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk_out("sw_stage", 7, 0, 1);
        go(s + 1 + DELAY);         chk_out("sw_restart_pre0", 7, 0, 1);
        go(s + 1 + DELAY + 1);     chk_out("sw_restart_rel0", 6, 0, 1);
        go(s + 1 + DELAY + 1 + 2*GAP); chk_out("sw_restart_rel2", 0, 1, 1);

        // Simultaneous lock loss and software request counts once
        m = cyc;
        glitch();
        go(m + FALL);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk_out("both", 7, 0, 2);
        r = m + 1 + LQ;
        go(r + DELAY + 1 + 2*GAP); chk_out("both_replay", 0, 1, 2);

        // Saturation: 252 more losses -> 254, then 255, then stays 255
        for (int i = 0; i < 252; i++) begin
            m = cyc;
            glitch();
            go(m + P);
        end
        chk("sat_254", 32'(relock_cnt), 254);
        m = cyc;
        glitch();
        go(m + P);
        chk("sat_255", 32'(relock_cnt), 255);
        m = cyc;
        glitch();
        go(m + P);
        chk("sat_hold", 32'(relock_cnt), 255);

        // Mid-sequence reset, then restart from WAIT_LOCK
        s = cyc;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_out("mid_rst", 7, 0, 0);
        go(s + REL0);              chk_out("mid_rst_pre0", 7, 0, 0);
        go(s + 1 + REL0);          chk_out("mid_rst_rel0", 6, 0, 0);
        go(s + 1 + REL0 + 2*GAP);  chk_out("mid_rst_rel2", 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/por_sequencer.md
POR_SEQUENCER -- requirements
Module: por_sequencer

Interface
REQ-001 SHALL have parameter DELAY, default 1023: cycles from qualified lock to release of channel 0.
REQ-002 SHALL have parameter CNT_W, default 10: delay and gap counter width; DELAY and STAGE_GAP fit in CNT_W.
REQ-003 SHALL have parameter NUM_CH, default 2: number of reset domains, 1..8.
REQ-004 SHALL have parameter STAGE_GAP, default 16: cycles between successive channel releases, >=1.
REQ-005 SHALL have parameter LOCK_FILT, default 4: consecutive high samples required by the lock filter, >=1.
REQ-006 SHALL have port clk, input, 1: sole clock; all state on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port pll_locked, input, 1: PLL lock, asynchronous to clk.
REQ-009 SHALL have port sw_rst_req, input, 1: synchronous request to re-run the sequence.
REQ-010 SHALL have port rst_out, output, NUM_CH: active-high resets to downstream domains; bit 0 is released first.
REQ-011 SHALL have port ready, output, 1: high once all channels are released.
REQ-012 SHALL have port relock_cnt, output, 8: count of lock losses, saturating.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; the output after qualification is lock_q.
REQ-014 SHALL implement the states WAIT_LOCK, COUNT, STAGE and RUN.
REQ-015 SHALL behave as follows in WAIT_LOCK: rst_out all ones, ready 0; when lock_q=1, go to COUNT and load the counter with DELAY.
REQ-016 SHALL behave as follows in COUNT: decrement once per cycle; at 0, go to STAGE, clear rst_out[0], set the stage index to 1 and load the gap counter with STAGE_GAP.
REQ-017 SHALL release channel k exactly DELAY+1+k*STAGE_GAP cycles after the first cycle lock_q is high in WAIT_LOCK.
REQ-018 SHALL behave as follows in STAGE: decrement the gap counter; at 0, clear the next rst_out bit and reload; after the last bit is cleared, go to RUN.
REQ-019 SHALL assert ready in the same cycle the final rst_out bit is cleared; with NUM_CH=1, go from COUNT directly to RUN and assert ready together with rst_out[0] release.
REQ-020 SHALL release rst_out bits in order only; once cleared, a bit stays 0 until re-assertion of all bits.
REQ-021 SHALL handle lock_q=0 in COUNT, STAGE or RUN: on the next edge, set rst_out to all ones, ready to 0, state to WAIT_LOCK, and increment relock_cnt (saturating at 255).
REQ-022 SHALL handle sw_rst_req=1 in COUNT, STAGE or RUN the same way as REQ-021, except relock_cnt is unchanged; sw_rst_req is ignored in WAIT_LOCK.
REQ-023 SHALL give lock loss priority when lock loss and sw_rst_req occur in the same cycle: relock_cnt increments exactly once.
REQ-024 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, set state to WAIT_LOCK, counters to 0, stage index to 0, rst_out to all ones, ready to 0, relock_cnt to 0, and clear synchronizer and filter flops.
REQ-026 SHALL apply rst_n mid-sequence in any state, taking effect at the next edge, and restart from WAIT_LOCK after release.

Configuration
REQ-027 SHALL, when macro POR_LOCK_FILTER_EN is defined, raise lock_q only after LOCK_FILT consecutive high synchronized samples, and drop lock_q on the first low synchronized sample (registered, 1 cycle).
REQ-028 SHALL, when POR_LOCK_FILTER_EN is undefined, make lock_q equal to the synchronizer output and omit the LOCK_FILT logic, which SHALL have no effect.

Verification (DELAY=8, STAGE_GAP=4, NUM_CH=3, LOCK_FILT=4)
REQ-029 SHALL cover reset: rst_n=0 for 3 cycles with pll_locked=0 -> rst_out=3'b111, ready=0, relock_cnt=0, held indefinitely after rst_n=1.
REQ-030 SHALL cover startup without the filter: pll_locked rises at cycle 0 -> lock_q=1 at cycle 2; rst_out=3'b110 at cycle 11, 3'b100 at cycle 15, 3'b000 with ready=1 at cycle 19.
REQ-031 SHALL cover lock loss: in RUN, pll_locked low for 1 cycle -> rst_out=3'b111 and ready=0 one edge after lock_q falls; relock_cnt=1; the full sequence replays with the same timing as REQ-030.
REQ-032 SHALL cover software reset: sw_rst_req pulse 1 cycle with rst_out=3'b110 -> rst_out=3'b111 next edge, relock_cnt unchanged; the sequence restarts.
REQ-033 SHALL cover the lock filter with POR_LOCK_FILTER_EN: a 3-cycle pll_locked glitch -> no change in state; a 4-cycle high -> sequence starts, with rst_out[0] released DELAY+1 cycles after lock_q rises.
REQ-034 SHALL cover saturation: 256 lock-loss events -> relock_cnt=255, unchanged by further losses; simultaneous loss and sw_rst_req -> +1 only.
